alu_seq_ctrl: RTL

- Sequential front-end that drives the 16-function combinational ALU (same 4-bit function encoding) and consumes its result.
- Holds an 8-entry register file and accepts 3-address instructions (rd, rs1, rs2, func) over a valid/ready handshake.
- For each instruction it presents operands and func to the ALU, waits ALU_LAT cycles, then writes RES back to rd.
- A host write port loads initial operands; a read port exposes register contents.

---
 rtl/alu_seq_ctrl_if.sv | 11 +
 rtl/alu_seq_ctrl.sv | 97 +++++++++
 2 files changed

// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: instruction valid/ready handshake carrying a 3-address ALU instruction
interface alu_seq_ctrl_if;
   logic       instr_valid;
   logic       instr_ready;
   logic [3:0] instr_func;
   logic [2:0] instr_rd;
   logic [2:0] instr_rs1;
   logic [2:0] instr_rs2;
   modport master (output instr_valid, instr_func, instr_rd, instr_rs1, instr_rs2, input instr_ready);
   modport slave (input instr_valid, instr_func, instr_rd, instr_rs1, instr_rs2, output instr_ready);
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: 8-entry register file sequencing instructions through an external ALU
// ALU_SEQ_CTRL_FLAGS_EN adds zero/negative flags registered at each writeback
module alu_seq_ctrl #(
   parameter int N       = 8,
   parameter int ALU_LAT = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   alu_seq_ctrl_if.slave   instr,
   output logic [N-1:0]    o_alu_a,
   output logic [N-1:0]    o_alu_b,
   output logic [3:0]      o_alu_func,
   input  logic [N-1:0]    i_alu_res,
   input  logic            i_wr_en,
   input  logic [2:0]      i_wr_addr,
   input  logic [N-1:0]    i_wr_data,
   input  logic [2:0]      i_rd_addr,
   output logic [N-1:0]    o_rd_data,
   output logic            o_done,
`ifdef ALU_SEQ_CTRL_FLAGS_EN
   output logic [N-1:0]    o_result,
   output logic            o_flag_z,
   output logic            o_flag_n
`else
   output logic [N-1:0]    o_result
`endif
);
   typedef enum logic {S_IDLE, S_EXEC} state_t;
   state_t       r_state, w_next;
   logic [3:0]   r_cnt;
   logic [2:0]   r_rd;
   logic [N-1:0] r_a, r_b, r_result;
   logic [3:0]   r_func;
   logic         r_done;
   logic [N-1:0] r_rf [8];
   logic         w_acc, w_wb;
   always_comb begin
      w_next = r_state;
      w_acc  = 1'b0;
      w_wb   = 1'b0;
      if (r_state == S_IDLE && instr.instr_valid) begin
         w_next = S_EXEC;
         w_acc  = 1'b1;
      end else if (r_state == S_EXEC && r_cnt == 4'd0) begin
         w_next = S_IDLE;
         w_wb   = 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_rd     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_func   <= '0;
         r_result <= '0;
         r_done   <= 1'b0;
         for (int i = 0; i < 8; i++) r_rf[i] <= '0;
      end else begin
         r_state <= w_next;
         r_done  <= w_wb;
         if (w_acc) begin
            r_a    <= r_rf[instr.instr_rs1];
            r_b    <= r_rf[instr.instr_rs2];
            r_func <= instr.instr_func;
            r_rd   <= instr.instr_rd;
            r_cnt  <= 4'(ALU_LAT);
         end else if (r_state == S_EXEC && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_wb) r_result <= i_alu_res;
         // writeback takes priority over a host write to the same register
         for (int i = 0; i < 8; i++)
            if (w_wb && r_rd == 3'(i)) r_rf[i] <= i_alu_res;
            else if (i_wr_en && i_wr_addr == 3'(i)) r_rf[i] <= i_wr_data;
      end
   end
`ifdef ALU_SEQ_CTRL_FLAGS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_flag_z <= 1'b0;
         o_flag_n <= 1'b0;
      end else if (w_wb) begin
         o_flag_z <= (i_alu_res == '0);
         o_flag_n <= i_alu_res[N-1];
      end
   end
`endif
   assign instr.instr_ready = (r_state == S_IDLE);
   assign o_alu_a    = r_a;
   assign o_alu_b    = r_b;
   assign o_alu_func = r_func;
   assign o_rd_data  = r_rf[i_rd_addr];
   assign o_done     = r_done;
   assign o_result   = r_result;
endmodule
